// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// sharing a single full_sub cell behind a start/ready/done handshake.

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bo
);
    assign diff = a ^ b ^ bin;
    assign bo   = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             borrow;
    logic             cell_diff, cell_bo;
    logic             last_bit;

    full_sub u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bo   (cell_bo)
    );

    assign last_bit = (state == RUN) && (cnt == LAST);
    assign ready    = (state == IDLE);
    assign busy     = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bo     <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= last_bit;
            if (state == IDLE && start) begin
                a_sh   <= a;
                b_sh   <= b;
                borrow <= bin;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                borrow <= cell_bo;
                res_sh <= {cell_diff, res_sh[WIDTH-1:1]};
                cnt    <= cnt + 1'b1;
                // Outputs only move on completion so partial results never show.
                if (cnt == LAST) begin
                    diff <= {cell_diff, res_sh[WIDTH-1:1]};
                    bo   <= cell_bo;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized self-checking bench for serial_sub_ctrl against an arithmetic model.

module tb_serial_sub_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             bin;
    logic             ready, busy, done, bo;
    logic [WIDTH-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_diff = '0;
    logic             exp_bo   = 1'b0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bo    (bo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: plain integer subtraction; negative result means a borrow out.
    task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        int d;
        d = int'(av) - int'(bv) - int'(bi);
        exp_diff = WIDTH'(d);
        exp_bo   = (d < 0);
    endtask

    // Called at a negedge in IDLE. noise scrambles inputs and pulses start during RUN.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic bi, input bit noise);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("diff_hold_run", diff, exp_diff);
            check("bo_hold_run", bo, exp_bo);
            if (noise) begin
                if (i == 2) begin
                    a = 8'h01; b = 8'h02; start = 1'b1;
                end else begin
                    a = WIDTH'($urandom); b = WIDTH'($urandom);
                    bin = 1'($urandom); start = 1'($urandom);
                end
            end
            @(negedge clk);
        end
        model(av, bv, bi);
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("ready_done", ready, 0);
        check("diff", diff, exp_diff);
        check("bo", bo, exp_bo);
        @(negedge clk);
        check("done_clear", done, 0);
        check("ready_idle", ready, 1);
        check("diff_hold", diff, exp_diff);
        check("bo_hold", bo, exp_bo);
    endtask

    initial begin
        int cnt, last, pulses;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", bo, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h35, 8'h12, 1'b0, 1'b0);
        run_op(8'h12, 8'h35, 1'b0, 1'b0);
        @(negedge clk);
        check("underflow_hold_diff", diff, 8'hDD);
        check("underflow_hold_bo", bo, 1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(8'h50, 8'h10, 1'b0, 1'b1);
        check("ignored_start_diff", diff, 8'h40);

        for (int k = 0; k < 20; k++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), bit'(k[0]));

        // Async reset while idle with a nonzero result held.
        run_op(8'h9C, 8'h21, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("idle_rst_diff", diff, 0);
        check("idle_rst_bo", bo, 0);
        check("idle_rst_ready", ready, 1);
        exp_diff = '0; exp_bo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset on RUN cycle 4.
        run_op(8'hF0, 8'h0F, 1'b0, 1'b0);
        a = 8'h33; b = 8'hEE; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_diff", diff, 0);
        check("mid_rst_bo", bo, 0);
        exp_diff = '0; exp_bo = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", done, 0);
        end

        // Back-to-back with start held high.
        a = 8'h0A; b = 8'h03; bin = 1'b0; start = 1'b1;
        cnt = 0; last = -1; pulses = 0;
        while (pulses < 3 && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (done) begin
                check("b2b_diff", diff, 8'h07);
                check("b2b_bo", bo, 0);
                if (last < 0) check("b2b_first_latency", cnt, 9);
                else          check("b2b_interval", cnt - last, WIDTH + 2);
                last = cnt;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 3);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtractor controller. Computes diff = a - b - bin over WIDTH bits, LSB first, one bit per clock.
- Each bit goes through a single internally instantiated full_sub cell (ports a, b, bin, diff, bo).
- Provides a start/ready/done handshake so a host FSM can share one 1-bit subtract cell across multi-bit operations.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  initial borrow-in; captured on the accepting edge.
- ready  output  1  high in IDLE (combinational state decode).
- busy  output  1  high in RUN (combinational state decode).
- done  output  1  registered one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered result; holds until the next completion.
- bo  output  1  registered final borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- States: IDLE, RUN, DONE. The state register is cleared asynchronously by rst.
- Reset (async, immediate, any state):
  - state = IDLE; bit counter, operand shift registers and borrow register = 0.
  - diff = 0, bo = 0, done = 0.
  - ready = 1 and busy = 0 while rst is held.
- IDLE:
  - On an edge with start = 1, capture a, b, bin into internal registers, clear the counter to 0, go to RUN.
  - With start = 0, stay in IDLE.
- RUN, one bit per edge:
  - The full_sub cell is fed the LSBs of the operand shift registers and the borrow register.
  - The cell's diff is shifted into the result shift register MSB-side.
  - The cell's bo is stored as the next borrow.
  - The operand registers shift right by 1 and the counter increments.
  - On the edge where counter == WIDTH-1, the completed result and final borrow load into the diff/bo output registers, done is set to 1, and the state goes to DONE.
- DONE:
  - Lasts exactly one cycle; done = 1 during it.
  - Next edge: done cleared, state goes to IDLE.
- Latency:
  - Accepting edge E0; RUN edges E1..E(WIDTH).
  - done is high in the cycle after E(WIDTH).
  - The next start can be accepted at E(WIDTH+2); minimum throughput is WIDTH+2 cycles per operation.
- start during RUN or DONE is ignored (not queued). Changes on a, b, bin after the accepting edge have no effect.
- diff and bo keep the previous result throughout RUN. They change only on the completion edge, so diff/bo never show partial results.
- Counter width is $clog2(WIDTH). There is no wrap beyond WIDTH-1, because the state exits RUN.
- Arithmetic is unsigned modulo 2^WIDTH; bo is the borrow out of the MSB.
- Reset mid-RUN aborts the operation: no done pulse, and diff/bo are cleared to 0. The first start after reset release behaves normally.

Test Plan:
- Reset: assert rst at time 0 and mid-idle -> diff=0, bo=0, done=0, busy=0, ready=1, asynchronously without waiting for a clock edge.
- Basic (WIDTH=8): a=8'h35, b=8'h12, bin=0, start pulse -> busy for 8 cycles, done pulse 8 cycles after the accepting edge, diff=8'h23, bo=0.
- Underflow: a=8'h12, b=8'h35, bin=0 -> diff=8'hDD, bo=1; diff and bo hold after done deasserts.
- Borrow-in extremes: a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bo=1. Then a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bo=1. Then a=8'hFF, b=8'h00, bin=0 -> diff=8'hFF, bo=0.
- Ignored start / input stability: start with a=8'h50, b=8'h10; during RUN pulse start again with a=8'h01, b=8'h02 -> exactly one done, diff=8'h40, bo=0.
- Reset mid-operation and back-to-back:
  - Assert rst on RUN cycle 4 -> immediate IDLE, no done pulse.
  - After release, hold start high with a=8'h0A, b=8'h03 -> done pulses every 10 cycles, each time with diff=8'h07, bo=0.
